// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for one shared combinational ALU. One operation is
//   in flight at a time. Each operation walks IDLE -> EXEC [-> WAIT] -> RESP.
//   Divide and remainder opcodes spend DIV_CYCLES extra cycles in WAIT so a slow
//   divider has time to settle. Ties are broken by round-robin.
//
// Parameters
//   DIV_CYCLES  extra settle cycles for divide/remainder opcodes (0..15)
//
// Ports
//   clk, rst_n                      clock; asynchronous active-low reset
//   req{0,1}_valid / req{0,1}_ready requester handshake; accept = valid & ready
//   req{0,1}_a, req{0,1}_b          8-bit operands
//   req{0,1}_oper                   5-bit ALU opcode
//   alu_a, alu_b, alu_oper          registered drive to the shared ALU
//   alu_r, alu_flag                 combinational ALU result and flags
//   rsp_valid / rsp_ready           response handshake
//   rsp_id                          index of the requester being answered
//   rsp_r, rsp_flag                 captured result and flags
module alu_arbiter #(
  parameter int unsigned DIV_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [4:0] req0_oper,
  input  logic [4:0] req1_oper,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_oper,
  input  logic [7:0] alu_r,
  input  logic [7:0] alu_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_r,
  output logic [7:0] rsp_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  // The WAIT countdown is preloaded with DIV_CYCLES-1, so WAIT lasts DIV_CYCLES cycles.
  localparam logic       DIV_EN   = (DIV_CYCLES != 0);
  localparam logic [3:0] DIV_LOAD = (DIV_CYCLES != 0) ? 4'(DIV_CYCLES - 1) : 4'd0;

  state_t     state_reg, state_next;
  logic [3:0] wait_cnt_reg, wait_cnt_next;
  logic       last_grant_reg;
  logic [7:0] alu_a_reg, alu_b_reg;
  logic [4:0] alu_oper_reg;
  logic       rsp_id_reg;
  logic [7:0] rsp_r_reg, rsp_flag_reg;

  logic       grant_any;
  logic       grant_id;
  logic       accept;
  logic       load_rsp;
  logic       oper_is_div;

  // Grant selection. When both requesters are valid, the one that did not win
  // last time gets the grant, so neither can be starved.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_reg;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is only offered from IDLE. It is also held low while reset is
  // asserted, so no requester sees an acceptance during reset.
  assign accept     = rst_n && (state_reg == IDLE) && grant_any;
  assign req0_ready = accept && (grant_id == 1'b0);
  assign req1_ready = accept && (grant_id == 1'b1);

  // Divide-class opcodes: 01110, 01111, 10010, 10011.
  always_comb begin
    oper_is_div = 1'b0;
    case (alu_oper_reg)
      5'b01110, 5'b01111, 5'b10010, 5'b10011: oper_is_div = 1'b1;
      default:                                oper_is_div = 1'b0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    load_rsp      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) state_next = EXEC;
      end
      EXEC: begin
        if (oper_is_div && DIV_EN) begin
          wait_cnt_next = DIV_LOAD;
          state_next    = WAIT;
        end else begin
          load_rsp   = 1'b1;
          state_next = RESP;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          load_rsp   = 1'b1;
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 4'd0;
      last_grant_reg <= 1'b1;
      alu_a_reg      <= 8'd0;
      alu_b_reg      <= 8'd0;
      alu_oper_reg   <= 5'd0;
      rsp_id_reg     <= 1'b0;
      rsp_r_reg      <= 8'd0;
      rsp_flag_reg   <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        last_grant_reg <= grant_id;
        rsp_id_reg     <= grant_id;
        alu_a_reg      <= grant_id ? req1_a    : req0_a;
        alu_b_reg      <= grant_id ? req1_b    : req0_b;
        alu_oper_reg   <= grant_id ? req1_oper : req0_oper;
      end
      if (load_rsp) begin
        rsp_r_reg    <= alu_r;
        rsp_flag_reg <= alu_flag;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_oper  = alu_oper_reg;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_id    = rsp_id_reg;
  assign rsp_r     = rsp_r_reg;
  assign rsp_flag  = rsp_flag_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 1: extra wait cycles inserted for divide/remainder opers (01110, 01111, 10010, 10011); legal range 0-15.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1 each  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1 each  requester's operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-007 SHALL have ports req0_oper / req1_oper  input  5 each  ALU operation code.
REQ-008 SHALL have ports alu_a, alu_b  output  8 each, and alu_oper  output  5  registered drive to the shared ALU.
REQ-009 SHALL have ports alu_r  input  8, and alu_flag  input  8  combinational ALU result and flags.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (requester index), rsp_r  output  8, rsp_flag  output  8.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, WAIT, RESP; exactly one transaction in flight.
REQ-012 In IDLE with no valid request, SHALL remain in IDLE, all ready low.
REQ-013 In IDLE, grant: only one valid -> that requester; both valid -> requester not equal to last_grant register.
REQ-014 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; valid&ready is the accept event.
REQ-015 On accept, SHALL latch operands/oper into alu_a/alu_b/alu_oper, latch id, update last_grant, go to EXEC.
REQ-016 Requester inputs SHALL be ignored outside the accept cycle; alu_* SHALL hold until next accept.
REQ-017 In EXEC: divide-class oper with DIV_CYCLES>0 -> load wait counter with DIV_CYCLES-1, go WAIT; otherwise capture alu_r/alu_flag into rsp_r/rsp_flag, go RESP.
REQ-018 In WAIT, SHALL decrement counter each cycle; at zero capture alu_r/alu_flag, go RESP.
REQ-019 In RESP, rsp_valid SHALL be high; rsp_r/rsp_flag/rsp_id stable until rsp_ready sampled high, then go IDLE.
REQ-020 Latency: accept at edge k -> rsp_valid high from edge k+2 (non-divide, or DIV_CYCLES=0); k+2+DIV_CYCLES for divide-class.
REQ-021 Minimum issue interval SHALL be 3 cycles (accept, EXEC, RESP with rsp_ready high).
REQ-022 Undefined opers (10101-11111) SHALL be issued as non-divide; response is whatever the ALU returns (0).
REQ-023 Arbitration SHALL be round-robin with no starvation: a continuously valid requester is granted within 2 transactions.
REQ-024 No new grant SHALL occur while rsp_valid is high, regardless of requester valids.

Reset
REQ-025 On rst_n low, SHALL enter IDLE immediately; alu_a, alu_b, alu_oper, rsp_r, rsp_flag, rsp_id, wait counter = 0; rsp_valid, req0_ready, req1_ready = 0; last_grant = 1 (req0 wins first tie).
REQ-026 Reset during EXEC/WAIT/RESP SHALL discard the in-flight transaction with no response issued.
REQ-027 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-028 Single req0, oper 00000, A=0x05 B=0x03, rsp_ready=1 -> req0_ready high accept cycle; rsp_valid at k+2 with rsp_r=0x08, rsp_id=0.
REQ-029 Both valid after reset, req0 oper 00100 A=0xF0 B=0x3C, req1 oper 00110 A=0xAA B=0xFF -> first rsp_id=0 rsp_r=0x30, then rsp_id=1 rsp_r=0x55.
REQ-030 DIV_CYCLES=2, req1 oper 01110 A=0x64 B=0x07 -> rsp_valid at k+4, rsp_r=0x0E; B=0x00 -> rsp_r=0xFF.
REQ-031 rsp_ready held low 3 cycles in RESP with req0_valid high -> rsp_valid and rsp_r stable, req0_ready stays low, accept only after handshake.
REQ-032 Both requesters continuously valid for 6 transactions -> rsp_id sequence 0,1,0,1,0,1.
REQ-033 rst_n pulsed low during WAIT -> all outputs zero, no rsp_valid; new request after release completes normally.
